mem_access_unit: RTL

- Memory-side stage directly downstream of the processor controller.
- Holds the MAR and MDR registers and consumes the controller's mar_load, mdr_load, m_en and m_rw strobes.
- Runs a single-outstanding req/ack transaction to the memory, returning read data into the MDR.
- Reports completion (done) or bus timeout (err) back to the controller.

---
 rtl/mem_access_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory access stage: MAR/MDR registers plus a single-outstanding req/ack bus
// transaction with timeout. Optional MAR post-increment via MAU_MAR_AUTOINC_EN.

module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mar_d,
    input  logic              mar_load,
    input  logic [DATA_W-1:0] mdr_d,
    input  logic              mdr_load,
    input  logic              m_en,
    input  logic              m_rw,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_t;

    // Last ACCESS cycle index before the transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic       rw_q;
    logic [7:0] cnt_q;

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            cnt_q   <= 8'd0;
            mar_q   <= '0;
            mdr_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mar_load) begin
                        mar_q <= mar_d;
                    end
                    if (mdr_load) begin
                        mdr_q <= mdr_d;
                    end
                    if (m_en) begin
                        rw_q    <= m_rw;
                        cnt_q   <= 8'd0;
                        mem_req <= 1'b1;
                        mem_we  <= ~m_rw;
                        busy    <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (mem_ack) begin
                        if (rw_q) begin
                            mdr_q <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
`ifdef MAU_MAR_AUTOINC_EN
                    mar_q   <= mar_q + ADDR_W'(1);
`else
                    mar_q   <= mar_q;
`endif
                end
                ERR: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
